// File: rtl/od_bus_pkg.sv
// Shared types and default timing for the single-wire open-drain bus.
// The transmitter block uses the same pulse-length constants.
package od_bus_pkg;

  typedef enum logic [2:0] {
    SYM_NONE,
    SYM_BIT0,
    SYM_BIT1,
    SYM_RESET,
    SYM_ILLEGAL
  } sym_e;

  typedef enum logic {
    IDLE,
    LOW
  } rx_state_e;

  localparam int DEF_W           = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_GLITCH      = 2;
  localparam int DEF_BIT1_MAX    = 15;
  localparam int DEF_BIT0_MAX    = 60;
  localparam int DEF_RST_MIN     = 480;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/od_sync_filter.sv
// Coerces the wired line (z/x read as 1), synchronises it and produces edge strobes.
// Edges are suppressed until a genuine high has been seen after reset.
module od_sync_filter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic od_line,
  output logic line_s,
  output logic rise,
  output logic fall
);

  logic                   line_in;
  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] fill;
  logic                   line_d;
  logic                   armed;

  assign line_in = (od_line !== 1'b0);

  // fill tracks which sync stages hold real samples rather than reset ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '1;
      fill   <= '0;
      line_d <= 1'b1;
      armed  <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], line_in};
      fill   <= {fill[SYNC_STAGES-2:0], 1'b1};
      line_d <= line_s;
      armed  <= armed | (fill[SYNC_STAGES-1] & line_s);
    end
  end

  assign line_s = sync[SYNC_STAGES-1];
  assign rise   = armed & ~line_d & line_s;
  assign fall   = armed & line_d & ~line_s;

endmodule

// File: rtl/od_line_receiver.sv
// Open-drain bus reader: times low pulses, decodes bit/reset symbols and
// assembles LSB-first words delivered over a valid/ready handshake.
module od_line_receiver
  import od_bus_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int GLITCH      = DEF_GLITCH,
  parameter int BIT1_MAX    = DEF_BIT1_MAX,
  parameter int BIT0_MAX    = DEF_BIT0_MAX,
  parameter int RST_MIN     = DEF_RST_MIN,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         od_line,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         bus_reset_o,
  output logic         err_o
);

  localparam int BC_W = (W > 1) ? $clog2(W) : 1;

  rx_state_e          state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [BC_W-1:0]    bit_cnt;
  logic [W-1:0]       shift_reg;
  logic [W-1:0]       word_nx;
  logic               line_s, rise, fall;
  logic               is_bit, complete, handshake;
  sym_e               sym;

  function automatic sym_e classify(input logic [CNT_W-1:0] c);
    if (c < CNT_W'(GLITCH))         return SYM_NONE;
    else if (c <= CNT_W'(BIT1_MAX)) return SYM_BIT1;
    else if (c <= CNT_W'(BIT0_MAX)) return SYM_BIT0;
    else if (c < CNT_W'(RST_MIN))   return SYM_ILLEGAL;
    else                            return SYM_RESET;
  endfunction

  od_sync_filter #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .od_line (od_line),
    .line_s  (line_s),
    .rise    (rise),
    .fall    (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Symbol is decoded in the same cycle the line returns high
  always_comb begin
    state_nx = state;
    sym      = SYM_NONE;
    case (state)
      IDLE: if (fall) state_nx = LOW;
      LOW: begin
        if (rise) begin
          state_nx = IDLE;
          sym      = classify(cnt);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == IDLE && fall) begin
      cnt <= CNT_W'(1);
    end else if (state == LOW && !line_s && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    word_nx          = shift_reg;
    word_nx[bit_cnt] = (sym == SYM_BIT1);
    is_bit           = (sym == SYM_BIT0) || (sym == SYM_BIT1);
    complete         = is_bit && (bit_cnt == BC_W'(W - 1));
    handshake        = valid_o & ready_i;
  end

  // A handshake in the same cycle frees the output register for the new word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      bus_reset_o <= 1'b0;
      err_o       <= 1'b0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
    end else begin
      bus_reset_o <= (sym == SYM_RESET);
      if (handshake) valid_o <= 1'b0;
      case (sym)
        SYM_BIT0, SYM_BIT1: begin
          if (complete) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            if (!valid_o || handshake) begin
              data_o  <= word_nx;
              valid_o <= 1'b1;
            end else begin
              err_o <= 1'b1;
            end
          end else begin
            shift_reg <= word_nx;
            bit_cnt   <= bit_cnt + 1'b1;
          end
        end
        SYM_ILLEGAL: begin
          err_o     <= 1'b1;
          bit_cnt   <= '0;
          shift_reg <= '0;
        end
        SYM_RESET: begin
          err_o     <= 1'b0;
          bit_cnt   <= '0;
          shift_reg <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
